// File: rtl/sram_pkg.sv
// Shared constants and request record for the 32x128 RW macro front-ends.
package sram_pkg;

  localparam int SRAM_DATA_WIDTH = 32;
  localparam int SRAM_ADDR_WIDTH = 7;

  typedef struct packed {
    logic                       we;
    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic [SRAM_DATA_WIDTH-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_port_ctrl_if.sv
// Request/response handshake bundle between a client and one sram_port_ctrl.
interface sram_port_ctrl_if
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_rsp_fifo.sv
// In-order read-response queue: push and pop at posedge, head is visible the cycle after push.
// Simultaneous push and pop leaves the count unchanged; the producer must never push into a full queue.
module sram_rsp_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 3,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count_q == CNT_W'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && count_q == '0));

endmodule

// File: rtl/sram_port_ctrl.sv
// Valid/ready front-end for one macro RW port: registered csb/web/addr/din, 2-cycle read latency.
// Requests are credited against queue space so the response queue never overflows under rsp backpressure.
module sram_port_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int RSP_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_port_ctrl_if.slave       bus,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  // S1 lives directly in the macro control flops: csb_q/web_q are the inverted valid/write bits.
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [15:0]           rd_count_q, rd_count_d;
  logic [15:0]           wr_count_q, wr_count_d;

  logic                  accept;
  logic                  s1_rd;
  logic                  fifo_pop;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        credit_used;

  assign s1_rd         = ~csb_q & web_q;
  assign credit_used   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_rd};
  assign bus.req_ready = credit_used < (CNT_W + 1)'(RSP_DEPTH);
  assign accept        = bus.req_valid & bus.req_ready;
  assign bus.rsp_valid = fifo_count != '0;
  assign fifo_pop      = bus.rsp_valid & bus.rsp_ready;

  always_comb begin
    csb_d      = 1'b1;
    web_d      = 1'b1;
    addr_d     = addr_q;
    din_d      = din_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (accept) begin
      csb_d  = 1'b0;
      web_d  = ~bus.req_we;
      addr_d = bus.req_addr;
      din_d  = bus.req_wdata;
      if (bus.req_we) begin
        wr_count_d = wr_count_q + 16'd1;
      end else begin
        rd_count_d = rd_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csb_q      <= 1'b1;
      web_q      <= 1'b1;
      addr_q     <= '0;
      din_q      <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      csb_q      <= csb_d;
      web_q      <= web_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Macro dout is combinational, so it is valid for the whole S1 read cycle.
  sram_rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s1_rd),
    .push_data (sram_dout),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .head      (bus.rsp_rdata)
  );

  assign sram_csb  = csb_q;
  assign sram_web  = web_q;
  assign sram_addr = addr_q;
  assign sram_din  = din_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with a behavioural macro (negedge write, combinational dout).
module tb_sram_port_ctrl;
  import sram_pkg::*;

  typedef struct {
    logic        req_valid;
    sram_req_t   req;
    logic        rsp_ready;
    logic        exp_ready;
    logic        exp_csb;
    logic        exp_web;
    logic        exp_rvld;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    logic [15:0] exp_rd;
    logic [15:0] exp_wr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        preload;
  logic        sram_csb, sram_web;
  logic [6:0]  sram_addr;
  logic [31:0] sram_din, sram_dout;
  logic [15:0] rd_count, wr_count;
  logic [31:0] mem [128];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) bus ();

  sram_port_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .RSP_DEPTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sram_csb  (sram_csb),
    .sram_web  (sram_web),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  // Macro model: contents survive controller reset, preload writes value = addr*3.
  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'(i * 3);
    end else if (!sram_csb && !sram_web) begin
      mem[sram_addr] <= sram_din;
    end
  end
  assign sram_dout = mem[sram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [6:0] a, input logic [31:0] d);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  function automatic vec_t mk(int v, int we, int a, int d, int rr, int rdy, int csb, int web,
                              int rvld, int chk_d, int rdata, int rd, int wr);
    vec_t m;
    m.req_valid  = 1'(v);
    m.req.we     = 1'(we);
    m.req.addr   = 7'(a);
    m.req.wdata  = 32'(d);
    m.rsp_ready  = 1'(rr);
    m.exp_ready  = 1'(rdy);
    m.exp_csb    = 1'(csb);
    m.exp_web    = 1'(web);
    m.exp_rvld   = 1'(rvld);
    m.chk_rdata  = 1'(chk_d);
    m.exp_rdata  = 32'(rdata);
    m.exp_rd     = 16'(rd);
    m.exp_wr     = 16'(wr);
    return m;
  endfunction

  vec_t vecs [16];

  initial begin
    int n_acc;
    int guard;
    bit mid_done;

    //           v we a   wdata         rr | rdy csb web rvld chk rdata        rd wr
    vecs[0]  = mk(1, 1, 5, 32'hDEADBEEF, 1,   1,  1,  1,  0,   1,  0,           0, 0);
    vecs[1]  = mk(1, 0, 5, 0,            1,   1,  0,  0,  0,   0,  0,           0, 1);
    vecs[2]  = mk(0, 0, 0, 0,            1,   1,  0,  1,  0,   0,  0,           1, 1);
    vecs[3]  = mk(0, 0, 0, 0,            1,   1,  1,  1,  1,   1,  32'hDEADBEEF, 1, 1);
    vecs[4]  = mk(0, 0, 0, 0,            0,   1,  1,  1,  0,   0,  0,           1, 1);
    vecs[5]  = mk(1, 0, 8, 0,            0,   1,  1,  1,  0,   0,  0,           1, 1);
    vecs[6]  = mk(1, 0, 9, 0,            0,   1,  0,  1,  0,   0,  0,           2, 1);
    vecs[7]  = mk(1, 0, 10, 0,           0,   1,  0,  1,  1,   1,  24,          3, 1);
    vecs[8]  = mk(1, 0, 11, 0,           0,   0,  0,  1,  1,   1,  24,          4, 1);
    vecs[9]  = mk(1, 0, 11, 0,           0,   0,  1,  1,  1,   1,  24,          4, 1);
    vecs[10] = mk(1, 0, 11, 0,           1,   0,  1,  1,  1,   1,  24,          4, 1);
    vecs[11] = mk(1, 0, 11, 0,           1,   1,  1,  1,  1,   1,  27,          4, 1);
    vecs[12] = mk(1, 0, 12, 0,           1,   1,  0,  1,  1,   1,  30,          5, 1);
    vecs[13] = mk(0, 0, 0, 0,            1,   1,  0,  1,  1,   1,  33,          6, 1);
    vecs[14] = mk(0, 0, 0, 0,            1,   1,  1,  1,  1,   1,  36,          6, 1);
    vecs[15] = mk(0, 0, 0, 0,            1,   1,  1,  1,  0,   0,  0,           6, 1);

    rst_n = 1'b0;
    preload = 1'b1;
    bus.rsp_ready = 1'b0;
    drive(1'b0, 1'b0, 7'd0, 32'd0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    preload = 1'b0;
    repeat (5) tick();

    // Reset state, write-then-read forwarding through the macro, then backpressure.
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("row%0d_req_ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("row%0d_csb", i),       32'(sram_csb),      32'(vecs[i].exp_csb));
      chk($sformatf("row%0d_web", i),       32'(sram_web),      32'(vecs[i].exp_web));
      chk($sformatf("row%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(vecs[i].exp_rvld));
      if (vecs[i].chk_rdata)
        chk($sformatf("row%0d_rsp_rdata", i), bus.rsp_rdata, vecs[i].exp_rdata);
      chk($sformatf("row%0d_rd_count", i), 32'(rd_count), 32'(vecs[i].exp_rd));
      chk($sformatf("row%0d_wr_count", i), 32'(wr_count), 32'(vecs[i].exp_wr));
      drive(vecs[i].req_valid, vecs[i].req.we, vecs[i].req.addr, vecs[i].req.wdata);
      bus.rsp_ready = vecs[i].rsp_ready;
    end

    // Streaming: refresh addr*3 contents, then 8 back-to-back reads.
    preload = 1'b1;
    @(negedge clk);
    #1;
    preload = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      tick();
      if (c < 8) chk($sformatf("stream%0d_req_ready", c), 32'(bus.req_ready), 32'd1);
      if (c >= 2 && c <= 9) begin
        chk($sformatf("stream%0d_rsp_valid", c), 32'(bus.rsp_valid), 32'd1);
        chk($sformatf("stream%0d_rsp_rdata", c), bus.rsp_rdata, 32'((c - 2) * 3));
      end
      if (c == 10) begin
        chk("stream_end_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("stream_end_rd_count", 32'(rd_count), 32'd14);
      end
      if (c < 8) drive(1'b1, 1'b0, 7'(c), 32'd0);
      else       drive(1'b0, 1'b0, 7'd0, 32'd0);
    end

    // Reset while a write sits in S1, before its negedge.
    tick();
    drive(1'b1, 1'b1, 7'h10, 32'h12345678);
    tick();
    chk("midrst_csb_before", 32'(sram_csb), 32'd0);
    chk("midrst_web_before", 32'(sram_web), 32'd0);
    drive(1'b0, 1'b0, 7'd0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_csb_async", 32'(sram_csb), 32'd1);
    chk("midrst_web_async", 32'(sram_web), 32'd1);
    chk("midrst_wr_count", 32'(wr_count), 32'd0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("midrst_sram_addr", 32'(sram_addr), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    drive(1'b1, 1'b0, 7'h10, 32'd0);
    tick();
    drive(1'b0, 1'b0, 7'd0, 32'd0);
    chk("midrst_read_lat1_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("midrst_read_valid", 32'(bus.rsp_valid), 32'd1);
    chk("midrst_read_data", bus.rsp_rdata, 32'h30);
    chk("midrst_rd_count", 32'(rd_count), 32'd1);
    tick();

    // Counter wrap on the write counter.
    n_acc = 0;
    guard = 0;
    mid_done = 1'b0;
    while (n_acc < 65537 && guard < 70000) begin
      drive(1'b1, 1'b1, 7'(n_acc), 32'(n_acc));
      if (bus.req_ready) n_acc++;
      tick();
      guard++;
      if (n_acc == 65536 && !mid_done) begin
        mid_done = 1'b1;
        chk("wrap_wr_count_65536", 32'(wr_count), 32'd0);
      end
    end
    drive(1'b0, 1'b0, 7'd0, 32'd0);
    chk("wrap_accept_total", 32'(n_acc), 32'd65537);
    chk("wrap_wr_count", 32'(wr_count), 32'd1);
    chk("wrap_rd_count", 32'(rd_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_ctrl.md
# sram_port_ctrl

Single-port request front-end for one RW port of the team's 2RW OpenRAM macro (32-bit × 128 words). It converts a valid/ready request stream (read or write) into registered, glitch-free `csb`/`web`/`addr`/`din` for the macro port and captures combinational `dout` into an in-order response queue with backpressure. One instance sits directly upstream of each macro port, for example a fetch port and a load/store port.

## Interface
- `DATA_WIDTH`, default 32: word width; must match the macro.
- `ADDR_WIDTH`, default 7: word address width (128 words).
- `RSP_DEPTH`, default 3: response queue entries; legal range 2..8; 3 gives full read throughput.
- `clk`  in  1: single clock. All state is updated on posedge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: request accepted when `req_valid` and `req_ready` are both high at posedge.
- `req_we`  in  1: 1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH: word address.
- `req_wdata`  in  DATA_WIDTH: write data.
- `rsp_valid`  out  1: read data available.
- `rsp_ready`  in  1: consumer takes the data at posedge.
- `rsp_rdata`  out  DATA_WIDTH: read data, head of queue.
- `sram_csb`  out  1: to macro `csb`, active low.
- `sram_web`  out  1: to macro `web`, active low.
- `sram_addr`  out  ADDR_WIDTH: to macro `addr`.
- `sram_din`  out  DATA_WIDTH: to macro `din`.
- `sram_dout`  in  DATA_WIDTH: from macro `dout`. This is combinational in the macro.
- `rd_count`, `wr_count`  out  16: accepted reads and writes, wrapping modulo 2^16.

## Operation
- **Issue stage S1 registers:** `s1_valid`, `s1_we`, `s1_addr`, `s1_wdata`.
  - On accept, S1 loads the request.
  - With no accept, `s1_valid` goes to 0. S1 always drains in one cycle.
- **Macro port drive:** `sram_csb = ~s1_valid` and `sram_web = ~(s1_valid & s1_we)`. Both are driven straight from flops. `sram_addr` and `sram_din` hold their last value while idle.
- **Write completion:** the macro writes on the negedge inside the S1 cycle. A write produces no response.
- **Read capture:** at the posedge ending an S1 read cycle, `sram_dout` is pushed into the response queue. This is sub-module `sram_rsp_fifo`, synchronous and in-order.
- **Credit rule:** `req_ready = (fifo_count + (s1_valid & ~s1_we)) < RSP_DEPTH`.
  - The rule applies to reads and writes alike, so `req_ready` never depends on `req_valid` or the payload.
  - There is no combinational path from `rsp_ready` to `req_ready`.
- **Response output:** `rsp_valid = fifo_count != 0`. `rsp_rdata` is the head entry.
  - A pop happens when `rsp_valid & rsp_ready`.
  - A simultaneous push and pop keeps the count unchanged.
  - Overflow cannot occur by construction. An assertion checks this.
- **Counters:** `rd_count` and `wr_count` increment on each accepted read or write respectively.
- **Ordering:** a write followed by a read to the same address in the next cycle returns the new data. The write lands at the negedge before the read cycle.

## Timing
- **Reset values:**
  - `sram_csb` = 1, `sram_web` = 1, `sram_addr` = 0, `sram_din` = 0.
  - `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0.
  - Both counters = 0, queue empty.
- **Read latency:** a read accepted at posedge N is in S1 during cycle N+1. Data is captured at posedge N+1 and `rsp_valid` is high in cycle N+2, a latency of 2 cycles.
- **Throughput:** one read per cycle is sustained when `rsp_ready` is held high with `RSP_DEPTH` ≥ 3. Writes are one per cycle whenever credit is available.
- **Full queue:** when the queue plus in-flight reads equals `RSP_DEPTH`, `req_ready` = 0. It reasserts the cycle after a pop.
- **Reset mid-operation:** `rst_n` low forces `sram_csb` = 1 immediately (asynchronously). An S1 write whose negedge has not yet occurred is dropped. Queue contents are discarded.
- **Idle behaviour:** `sram_csb` stays high whenever no request was accepted in the previous cycle. The macro is never selected with X controls.

## Structure
- **Shared package `sram_pkg`:**
  - Constants: `SRAM_DATA_WIDTH` = 32, `SRAM_ADDR_WIDTH` = 7.
  - Typedef `sram_req_t`: `we`, `addr`, `wdata`.
- **Sub-module `sram_rsp_fifo`:** parameterised by width and depth. It provides `push`, `pop`, `count`, `head`, with pointer wrap-around at `RSP_DEPTH`.
- **Top level** holds S1, the credit logic and the counters.

## Test plan
- **Reset values:** reset, then idle for 5 cycles → `sram_csb` = 1, `sram_web` = 1, `req_ready` = 1, `rsp_valid` = 0, counters 0.
- **Write then read, same address:** write addr 0x05 data 0xDEADBEEF, then read addr 0x05 on the next cycle.
  - Expect `rsp_rdata` = 0xDEADBEEF with `rsp_valid` exactly 2 cycles after the read accept.
  - Expect `wr_count` = 1 and `rd_count` = 1.
- **Streaming reads:** 8 back-to-back reads of addr 0..7, preloaded with value = addr × 3, with `rsp_ready` = 1.
  - Expect `req_ready` never to drop.
  - Expect responses 0, 3, …, 21 in order on consecutive cycles.
- **Backpressure:** `rsp_ready` = 0 while 5 reads are offered.
  - Expect exactly 3 accepted, after which `req_ready` = 0.
  - Raise `rsp_ready`: the 3 responses drain in order and the remaining 2 reads are accepted after the pops.
- **Reset mid-write:** accept a write of 0x12345678 to addr 0x10, then assert `rst_n` low before the next negedge.
  - Expect `sram_csb` = 1 immediately.
  - After reset, a read of 0x10 returns the pre-existing value, not 0x12345678.
- **Counter wrap:** 65,537 accepted writes → `wr_count` = 1.
